// File: rtl/bank_drain_scheduler.sv
// Drains accumulator banks one entry at a time in entry-major order, one read in flight,
// emitting each captured word as a valid/ready beat tagged with its skewed tile coordinates.
module bank_drain_scheduler #(
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 256,
  parameter int DATA_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(TILE_SIZE):0]    num_rows,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [$clog2(BANK_COUNT)-1:0] rd_bank,
  output logic [$clog2(TILE_SIZE)-1:0]  rd_entry,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(TILE_SIZE)-1:0]  out_row,
  output logic [$clog2(BANK_COUNT)-1:0] out_column,
  output logic [DATA_W-1:0]             out_data
);

  localparam int BW = $clog2(BANK_COUNT);
  localparam int EW = $clog2(TILE_SIZE);
  localparam int NW = EW + 1;
  // Wide enough for 3*entry before reducing modulo BANK_COUNT
  localparam int TW = ((EW + 2) > BW) ? (EW + 2) : BW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t        state_r;
  logic [NW-1:0] rows_r;

  logic [NW-1:0] rows_sat_s;
  logic [TW-1:0] entry_ext_s;
  logic [TW-1:0] triple_s;
  logic [BW-1:0] column_s;
  logic          last_bank_s;
  logic          last_entry_s;

  // Row-count saturation, column skew and end-of-drain detection
  always_comb begin
    rows_sat_s   = (num_rows > NW'(TILE_SIZE)) ? NW'(TILE_SIZE) : num_rows;
    entry_ext_s  = TW'(rd_entry);
    triple_s     = (entry_ext_s << 1'b1) + entry_ext_s;
    // Power-of-two bank count: truncating subtraction is the wrapped modulo
    column_s     = rd_bank - triple_s[BW-1:0];
    last_bank_s  = (rd_bank == BW'(BANK_COUNT - 1));
    last_entry_s = ((NW'(rd_entry) + NW'(1)) == rows_r);
  end

  // Drain sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rows_r     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_bank    <= '0;
      rd_entry   <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_column <= '0;
      out_data   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            rd_bank  <= '0;
            rd_entry <= '0;
            if (num_rows != '0) begin
              rows_r  <= rows_sat_s;
              rd_en   <= 1'b1;
              state_r <= READ;
            end else begin
              done    <= 1'b1;
              state_r <= FINISH;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          rd_en   <= 1'b0;
          state_r <= WAIT;
        end
        WAIT: begin
          out_data   <= rd_data;
          out_row    <= rd_entry;
          out_column <= column_s;
          out_valid  <= 1'b1;
          state_r    <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_bank_s && last_entry_s) begin
              done    <= 1'b1;
              state_r <= FINISH;
            end else begin
              if (last_bank_s) begin
                rd_bank  <= '0;
                rd_entry <= rd_entry + EW'(1);
              end else begin
                rd_bank  <= rd_bank + BW'(1);
              end
              rd_en   <= 1'b1;
              state_r <= READ;
            end
          end else begin
            out_valid <= 1'b1;
          end
        end
        FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_drain_scheduler.sv
// Directed and randomized drains of a 4-bank, 16-entry scheduler, checked against
// a beat-index reference model (beat k -> entry k/BC, bank k%BC).
module tb_bank_drain_scheduler;

  localparam int BC = 4;
  localparam int TS = 16;
  localparam int DW = 16;
  localparam int BW = $clog2(BC);
  localparam int EW = $clog2(TS);
  localparam int NW = EW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] num_rows;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [BW-1:0] rd_bank;
  logic [EW-1:0] rd_entry;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_row;
  logic [BW-1:0] out_column;
  logic [DW-1:0] out_data;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] salt = '0;

  bank_drain_scheduler #(.BANK_COUNT(BC), .TILE_SIZE(TS), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_bank(rd_bank), .rd_entry(rd_entry),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_column(out_column), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input int b, input int e);
    return DW'(b * 16 + e) ^ salt;
  endfunction

  function automatic int exp_col(input int k);
    int b;
    int e;
    b = k % BC;
    e = k / BC;
    return (b - ((3 * e) % BC) + BC) % BC;
  endfunction

  // Bank memory: data appears exactly one cycle after the read strobe, garbage otherwise
  always @(posedge clk)
    rd_data <= rd_en ? mem_val(int'(rd_bank), int'(rd_entry)) : DW'($urandom);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_rd_bank"}, rd_bank, 0);
    check({tag, "_rd_entry"}, rd_entry, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_column"}, out_column, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic drain(input int req, input int stall_pct, input int hold_beat,
                       input bit spam, input int abort_after);
    int nrows, total, k, rd_pulses, hs_cycle, cycle, hold_left;
    bit seen_valid, done_seen, aborted, fin, stalled;
    nrows = (req > TS) ? TS : req;
    total = nrows * BC;
    k = 0; rd_pulses = 0; hs_cycle = 0; hold_left = 5;
    seen_valid = 0; done_seen = 0; aborted = 0; fin = 0; stalled = 0;
    @(negedge clk);
    start = 1'b1; num_rows = NW'(req); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cycle = 1;
    for (int t = 0; t < 4000 && !fin; t++) begin
      check("busy", busy, 1);
      if (stalled) check("valid_held", out_valid, 1);
      if (rd_en) begin
        rd_pulses++;
        check("rd_one_outstanding", rd_pulses, k + 1);
        check("rd_no_overlap", out_valid, 0);
        check("rd_bank", rd_bank, k % BC);
        check("rd_entry", rd_entry, k / BC);
      end
      if (out_valid) begin
        check("valid_in_range", k < total, 1);
        if (!seen_valid) begin
          check("beat_latency", cycle, hs_cycle + 3);
          seen_valid = 1;
        end
        check("out_row", out_row, k / BC);
        check("out_column", out_column, exp_col(k));
        check("out_data", out_data, mem_val(k % BC, k / BC));
      end
      if (done) begin
        check("done_beats", k, total);
        check("done_timing", cycle, hs_cycle + 1);
        check("rd_count", rd_pulses, total);
        done_seen = 1;
        fin = 1;
      end else begin
        if (k == hold_beat && hold_left > 0 && out_valid) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = ($urandom_range(99) >= stall_pct);
        end
        if (spam) begin
          start = 1'($urandom_range(1));
          num_rows = NW'($urandom_range(TS));
        end
        stalled = out_valid && !out_ready;
        if (out_valid && out_ready) begin
          k++;
          hs_cycle = cycle;
          seen_valid = 0;
        end
        @(negedge clk);
        cycle++;
        if (abort_after >= 0 && k >= abort_after) begin
          aborted = 1;
          fin = 1;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!aborted) check("drain_completed", done_seen, 1);
    if (done_seen) begin
      @(negedge clk);
      check("busy_cleared", busy, 0);
      check("done_single_cycle", done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_rows = '0; out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reference table case: rd_data = bank*16 + entry
    drain(2, 0, -1, 1'b0, -1);
    // Zero rows: done only, no reads, no beats
    drain(0, 0, -1, 1'b0, -1);
    // Downstream holds off beat 1 for 5 cycles
    drain(3, 0, 1, 1'b0, -1);
    // Start pulses while busy must not disturb the drain
    drain(2, 30, -1, 1'b1, -1);
    // Oversized row request saturates at TS
    salt = DW'($urandom);
    drain(TS + 3, 20, -1, 1'b0, -1);

    // Abort after the third beat
    salt = '0;
    drain(2, 0, -1, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_abort", done, 0);
      check("idle_after_abort", busy, 0);
    end
    drain(1, 0, -1, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      salt = DW'($urandom);
      drain($urandom_range(TS + 4), $urandom_range(50), -1, 1'($urandom_range(1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
